// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_WIDTH  = 32;
    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of {pc, instr} entries with synchronous clear.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 64,
    parameter  int unsigned DEPTH      = 2,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                   clock_i,
    input  logic                   resetN_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [ADDR_WIDTH-1:0]  push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    output logic [ADDR_WIDTH-1:0]  head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   empty_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage and pointers; clear wins over push/pop, pointers wrap naturally.
    always_ff @(posedge clock_i or negedge resetN_i) begin
        if (!resetN_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_pc_i, push_instr_i};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_pc_o    = mem_q[rd_ptr_q].pc;
    assign head_instr_o = mem_q[rd_ptr_q].instr;
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited imem requests, instruction buffer, redirect/flush.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           BUF_DEPTH  = 2
) (
    input  logic                   clock,
    input  logic                   resetN,
    output logic                   imemReqValid,
    input  logic                   imemReqReady,
    output logic [ADDR_WIDTH-1:0]  imemReqAddr,
    input  logic                   imemRespValid,
    input  logic [INSTR_WIDTH-1:0] imemRespData,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instrPC,
    input  logic                   redirectValid,
    input  logic [ADDR_WIDTH-1:0]  redirectTarget
);

    localparam int unsigned           CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W:0]        DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(PC_INCREMENT);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      drop_q, drop_d;

    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       fifoCount;
    logic [CNT_W:0]         credit_used;
    logic                   redirect;
    logic                   req_fire;
    logic                   resp_keep;
    logic                   pop_fire;
    logic                   fifo_empty;
    logic [ADDR_WIDTH-1:0]  resp_addr;
    logic [INSTR_WIDTH-1:0] addrq_instr_unused;
    logic                   addrq_empty_unused;

    assign redirect     = redirectValid && (state_q != IDLE);
    assign credit_used  = {1'b0, outstanding} + {1'b0, fifoCount};
    assign imemReqValid = (state_q == RUN) && !redirectValid && (credit_used < DEPTH_LIM);
    assign imemReqAddr  = pc_q;
    assign req_fire     = imemReqValid && imemReqReady;
    assign resp_keep    = imemRespValid && (state_q == RUN) && !redirect;
    assign instrValid   = !fifo_empty;
    assign pop_fire     = instrValid && instrReady && !redirect;

    // Next PC, drop counter and state; redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (req_fire) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (imemRespValid && (drop_q != '0)) begin
                    drop_d = drop_q - CNT_W'(1);
                    if (drop_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_d    = {redirectTarget[ADDR_WIDTH-1:2], 2'b00};
            drop_d  = outstanding + drop_q - CNT_W'(imemRespValid);
            state_d = (drop_d != '0) ? FLUSH : RUN;
        end
    end

    // FSM, PC and drop counter registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Pending-address queue: its occupancy is the outstanding-request count,
    // and its head is the PC that the next kept response belongs to.
    fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_addr_q (
        .clock_i      (clock),
        .resetN_i     (resetN),
        .clear_i      (redirect),
        .push_i       (req_fire),
        .pop_i        (resp_keep),
        .push_pc_i    (pc_q),
        .push_instr_i ('0),
        .head_pc_o    (resp_addr),
        .head_instr_o (addrq_instr_unused),
        .count_o      (outstanding),
        .empty_o      (addrq_empty_unused)
    );

    fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_instr_buf (
        .clock_i      (clock),
        .resetN_i     (resetN),
        .clear_i      (redirect),
        .push_i       (resp_keep),
        .pop_i        (pop_fire),
        .push_pc_i    (resp_addr),
        .push_instr_i (imemRespData),
        .head_pc_o    (instrPC),
        .head_instr_o (instruction),
        .count_o      (fifoCount),
        .empty_o      (fifo_empty)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: cache model, stream model, directed + random phases.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int unsigned AW     = 64;
    localparam int unsigned DEPTH  = 2;
    localparam logic [AW-1:0] RST_PC = 64'h100;

    logic          clock  = 1'b0;
    logic          resetN = 1'b0;
    logic          imemReqValid;
    logic          imemReqReady  = 1'b0;
    logic [AW-1:0] imemReqAddr;
    logic          imemRespValid = 1'b0;
    logic [31:0]   imemRespData  = '0;
    logic          instrValid;
    logic          instrReady    = 1'b0;
    logic [31:0]   instruction;
    logic [AW-1:0] instrPC;
    logic          redirectValid = 1'b0;
    logic [AW-1:0] redirectTarget = '0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (RST_PC),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .imemReqValid   (imemReqValid),
        .imemReqReady   (imemReqReady),
        .imemReqAddr    (imemReqAddr),
        .imemRespValid  (imemRespValid),
        .imemRespData   (imemRespData),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instruction    (instruction),
        .instrPC        (instrPC),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory contents the cache returns for any word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    // ---------------- cache model ----------------
    typedef struct { logic [63:0] addr; int unsigned due; } pend_t;
    pend_t       cq[$];
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat_lo = 1, lat_hi = 1;
    bit          force_ready = 1'b1;
    bit          junk_resp = 1'b0;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (!resetN) begin
            imemReqReady  = 1'b1;
            imemRespValid = junk_resp;
            imemRespData  = $urandom;
        end else begin
            imemReqReady = force_ready ? 1'b1 : ($urandom_range(3) != 0);
            if (cq.size() != 0 && cq[0].due <= cyc) begin
                imemRespValid = 1'b1;
                imemRespData  = mem_word(cq[0].addr);
            end else begin
                imemRespValid = 1'b0;
                imemRespData  = $urandom;
            end
        end
    end

    always @(negedge clock) begin : cache_book
        int unsigned d;
        if (!resetN) begin
            cq.delete();
            last_due = 0;
        end else begin
            if (imemRespValid && cq.size() != 0) void'(cq.pop_front());
            if (imemReqValid && imemReqReady) begin
                d = cyc + $urandom_range(lat_hi, lat_lo);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                cq.push_back('{imemReqAddr, d});
            end
        end
    end

    // ---------------- stream model + scoreboard ----------------
    typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
    exp_t          sb[$];
    logic [AW-1:0] mpc = RST_PC;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!resetN) begin
            sb.delete();
            mpc = RST_PC;
        end else begin
            if (redirectValid) chk("req_during_redirect", imemReqValid, 0);
            if (imemReqValid && imemReqReady) begin
                chk("req_addr", imemReqAddr, mpc);
                sb.push_back('{mpc, mem_word(mpc)});
                mpc = mpc + 64'd4;
            end
            if (instrValid && instrReady && !redirectValid) begin
                if (sb.size() == 0) begin
                    chk("deliver_unexpected_pc", instrPC, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = sb.pop_front();
                    chk("deliver_pc", instrPC, e.pc);
                    chk("deliver_instr", instruction, 64'(e.ins));
                end
            end
            if (redirectValid) begin
                sb.delete();
                mpc = redirectTarget & ~64'h3;
            end
            chk("credit_limit", sb.size() <= DEPTH, 1);
        end
    end

    // ---------------- directed / random stimulus ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic samp();
        @(negedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_reqValid"}, imemReqValid, 0);
        chk({nm, "_reqAddr"}, imemReqAddr, RST_PC);
        chk({nm, "_instrValid"}, instrValid, 0);
        chk({nm, "_instruction"}, instruction, 0);
        chk({nm, "_instrPC"}, instrPC, 0);
    endtask

    task automatic do_reset();
        redirectValid = 1'b0;
        resetN = 1'b0;
        junk_resp = 1'b1;
        repeat (3) step();
        junk_resp = 1'b0;
        repeat (2) step();
        chk_reset_outputs("reset");
        resetN = 1'b1;
    endtask

    task automatic quiesce(input int unsigned lat);
        instrReady = 1'b0;
        lat_lo = lat;
        lat_hi = lat;
        repeat (10) step();
    endtask

    task automatic wait_instr(input string nm, input logic [63:0] pc);
        int unsigned n = 0;
        while (!instrValid && n < 50) begin step(); samp(); n++; end
        chk({nm, "_valid"}, instrValid, 1);
        chk({nm, "_pc"}, instrPC, pc);
    endtask

    task automatic wait_req(input string nm, input logic [63:0] addr);
        int unsigned n = 0;
        while (!imemReqValid && n < 50) begin step(); samp(); n++; end
        chk({nm, "_valid"}, imemReqValid, 1);
        chk({nm, "_addr"}, imemReqAddr, addr);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int unsigned nreq;
        int unsigned owed;
        int unsigned n;
        bit          found;

        // Start-up: consecutive requests and first-delivery latency.
        force_ready = 1'b1;
        instrReady  = 1'b1;
        do_reset();
        samp(); chk("idle_no_req", imemReqValid, 0);
        step(); samp(); chk("start_req0_valid", imemReqValid, 1); chk("start_req0_addr", imemReqAddr, 64'h100);
        step(); samp(); chk("start_req1_addr", imemReqAddr, 64'h104); chk("start_not_yet_valid", instrValid, 0);
        step(); samp(); chk("start_req2_addr", imemReqAddr, 64'h108);
        chk("start_first_valid", instrValid, 1); chk("start_first_pc", instrPC, 64'h100);

        // Back-pressure from reset: exactly two requests, head held stable.
        instrReady = 1'b0;
        do_reset();
        nreq = 0;
        repeat (10) begin
            samp();
            if (imemReqValid && imemReqReady) nreq++;
            step();
        end
        chk("bp_req_count", nreq, 2);
        samp();
        chk("bp_stall", imemReqValid, 0);
        chk("bp_head_pc", instrPC, 64'h100);
        chk("bp_head_instr", instruction, 64'(mem_word(64'h100)));
        step(); instrReady = 1'b1;
        samp(); chk("bp_head_stable", instrPC, 64'h100);
        step(); samp();
        chk("bp_resume_valid", imemReqValid, 1); chk("bp_resume_addr", imemReqAddr, 64'h108);

        // Redirect with full FIFO and nothing in flight.
        step(); quiesce(1);
        redirectValid = 1'b1; redirectTarget = 64'h2003;
        samp(); chk("redir_blocks_req", imemReqValid, 0);
        step(); redirectValid = 1'b0; instrReady = 1'b1;
        samp();
        chk("redir_flushed", instrValid, 0);
        chk("redir_req_valid", imemReqValid, 1);
        chk("redir_req_addr", imemReqAddr, 64'h2000);
        wait_instr("redir_first", 64'h2000);

        // Redirect with two requests in flight at latency 3.
        step(); quiesce(3);
        instrReady = 1'b1; redirectValid = 1'b1; redirectTarget = 64'h3000;
        step(); redirectValid = 1'b0;
        samp(); chk("flush_req0_addr", imemReqAddr, 64'h3000); chk("flush_req0_valid", imemReqValid, 1);
        step(); samp(); chk("flush_req1_addr", imemReqAddr, 64'h3004); chk("flush_req1_valid", imemReqValid, 1);
        step(); redirectValid = 1'b1; redirectTarget = 64'h400;
        samp(); chk("flush_credit_full", imemReqValid, 0);
        step(); redirectValid = 1'b0;
        samp(); chk("flush_cyc1_no_req", imemReqValid, 0); chk("flush_cyc1_no_instr", instrValid, 0);
        step(); samp(); chk("flush_cyc2_no_req", imemReqValid, 0);
        step(); samp(); chk("flush_exit_valid", imemReqValid, 1); chk("flush_exit_addr", imemReqAddr, 64'h400);
        wait_instr("flush_first", 64'h400);

        // Redirect coinciding with a response and a pop.
        lat_lo = 1; lat_hi = 1; instrReady = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            step();
            found = imemRespValid && instrValid;
            n++;
        end
        redirectValid = 1'b1; redirectTarget = 64'h500;
        samp(); owed = cq.size();
        chk("simul_found", found, 1);
        step(); redirectValid = 1'b0;
        samp();
        chk("simul_flushed", instrValid, 0);
        chk("simul_req_after", imemReqValid, owed == 0);
        wait_req("simul_req", 64'h500);
        wait_instr("simul_first", 64'h500);

        // PC wrap-around at the top of the address space.
        step(); quiesce(1);
        redirectValid = 1'b1; redirectTarget = 64'hFFFF_FFFF_FFFF_FFFF;
        step(); redirectValid = 1'b0; instrReady = 1'b1;
        samp(); chk("wrap_req0_addr", imemReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(); samp(); chk("wrap_req1_valid", imemReqValid, 1); chk("wrap_req1_addr", imemReqAddr, 64'h0);
        wait_instr("wrap_first", 64'hFFFF_FFFF_FFFF_FFFC);

        // Asynchronous reset asserted in the middle of FLUSH.
        step(); quiesce(3);
        instrReady = 1'b1; redirectValid = 1'b1; redirectTarget = 64'h3000;
        step(); redirectValid = 1'b0;
        step();
        step(); redirectValid = 1'b1; redirectTarget = 64'h400;
        step(); redirectValid = 1'b0;
        #1;
        chk("async_pre_addr", imemReqAddr, 64'h400);
        resetN = 1'b0;
        #1;
        chk_reset_outputs("async");

        // Randomized traffic with random redirects, then drain.
        force_ready = 1'b0; lat_lo = 1; lat_hi = 3;
        do_reset();
        step(); step();
        repeat (3000) begin
            instrReady     = ($urandom_range(3) != 0);
            redirectValid  = ($urandom_range(99) < 3);
            redirectTarget = {$urandom, $urandom};
            step();
        end
        redirectValid = 1'b0; instrReady = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin step(); n++; end
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
